// File: rtl/clock_gen_irq_intr_slave_if.sv
// AXI4-Lite bus bundle for the clock_gen_irq interrupt-controller responder.
// The master modport drives requests; the slave modport drives responses.
interface clock_gen_irq_intr_slave_if #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]                      awprot;
   logic                            awvalid;
   logic                            awready;
   logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                            wvalid;
   logic                            wready;
   logic [1:0]                      bresp;
   logic                            bvalid;
   logic                            bready;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
   logic [2:0]                      arprot;
   logic                            arvalid;
   logic                            arready;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                      rresp;
   logic                            rvalid;
   logic                            rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/clock_gen_irq_intr_slave.sv
// AXI4-Lite interrupt-controller register bank (GIE/IER/ISR/IAR/IPR) with registered irq.
// Define CLOCK_GEN_IRQ_EDGE_DETECT_EN for rising-edge source detection; default is level mode.
module clock_gen_irq_intr_slave #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter int unsigned C_NUM_OF_INTR      = 1,
   parameter bit          IRQ_ACTIVE_STATE   = 1'b1
) (
   input  logic                         S_AXI_ACLK,
   input  logic                         S_AXI_ARESETN,
   clock_gen_irq_intr_slave_if.slave    s_axi,
   input  logic [C_NUM_OF_INTR-1:0]     intr_src,
   output logic                         irq
);
   localparam int unsigned N = C_NUM_OF_INTR;
   localparam logic [2:0] AddrGie = 3'd0;
   localparam logic [2:0] AddrIer = 3'd1;
   localparam logic [2:0] AddrIsr = 3'd2;
   localparam logic [2:0] AddrIar = 3'd3;
   localparam logic [2:0] AddrIpr = 3'd4;

   logic          wr_ack_q, wr_ack_d;
   logic          bvalid_q, bvalid_d;
   logic          arready_q, arready_d;
   logic          rvalid_q, rvalid_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          gie_q, gie_d;
   logic [N-1:0]  ier_q, ier_d;
   logic [N-1:0]  isr_q, isr_d;
   logic          irq_q, irq_d;

   logic          wr_en, rd_en;
   logic [N-1:0]  wmask, iar_clr, evt;
   logic [31:0]   rd_mux;
   logic          unused_ok;

   assign unused_ok = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.awprot, s_axi.arprot,
                        s_axi.wstrb, s_axi.wdata};

   assign wr_en = s_axi.awvalid & s_axi.wvalid & ~wr_ack_q & ~bvalid_q;
   assign rd_en = s_axi.arvalid & ~arready_q & ~rvalid_q;

`ifdef CLOCK_GEN_IRQ_EDGE_DETECT_EN
   logic [N-1:0] src_q;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) src_q <= '0;
      else                src_q <= intr_src;
   end

   assign evt = intr_src & ~src_q;
`else
   assign evt = intr_src;
`endif

   always_comb begin
      for (int i = 0; i < int'(N); i++) wmask[i] = s_axi.wstrb[i/8];
   end

   always_comb begin
      wr_ack_d  = wr_en;
      bvalid_d  = bvalid_q;
      gie_d     = gie_q;
      ier_d     = ier_q;
      iar_clr   = '0;
      if (wr_ack_q)                   bvalid_d = 1'b1;
      else if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;
      if (wr_en) begin
         case (s_axi.awaddr[4:2])
            AddrGie: if (s_axi.wstrb[0]) gie_d = s_axi.wdata[0];
            AddrIer: ier_d = (ier_q & ~wmask) | (s_axi.wdata[N-1:0] & wmask);
            AddrIar: iar_clr = s_axi.wdata[N-1:0] & wmask;
            default: ;
         endcase
      end
      // A new event on the same edge as an acknowledge wins.
      isr_d = (isr_q & ~iar_clr) | evt;
      irq_d = (gie_q && |(isr_q & ier_q)) ? IRQ_ACTIVE_STATE : ~IRQ_ACTIVE_STATE;
   end

   always_comb begin
      rd_mux = '0;
      case (s_axi.araddr[4:2])
         AddrGie: rd_mux = {31'b0, gie_q};
         AddrIer: rd_mux = 32'(ier_q);
         AddrIsr: rd_mux = 32'(isr_q);
         AddrIpr: rd_mux = 32'(isr_q & ier_q);
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      arready_d = rd_en;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      if (rd_en) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
      end else if (rvalid_q && s_axi.rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wr_ack_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         gie_q     <= 1'b0;
         ier_q     <= '0;
         isr_q     <= '0;
         irq_q     <= ~IRQ_ACTIVE_STATE;
      end else begin
         wr_ack_q  <= wr_ack_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         gie_q     <= gie_d;
         ier_q     <= ier_d;
         isr_q     <= isr_d;
         irq_q     <= irq_d;
      end
   end

   assign s_axi.awready = wr_ack_q;
   assign s_axi.wready  = wr_ack_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = 2'b00;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = 2'b00;
   assign irq           = irq_q;
endmodule

// File: tb/tb_clock_gen_irq_intr_slave.sv
// Directed bench for clock_gen_irq_intr_slave: register access, irq timing, acknowledge,
// back-pressure, byte strobes and mid-transaction reset.
module tb_clock_gen_irq_intr_slave;
   localparam bit Act   = 1'b1;
   localparam bit Inact = !Act;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [0:0] intr_src;
   logic       irq;
   int         total = 0;
   int         bad = 0;

   clock_gen_irq_intr_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) bus ();

   clock_gen_irq_intr_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (5),
      .C_NUM_OF_INTR      (1),
      .IRQ_ACTIVE_STATE   (Act)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .s_axi         (bus),
      .intr_src      (intr_src),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required finish before 500us");
      $fatal(1);
   end

   task automatic idle_bus();
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic irq0, output logic irq1,
                            output logic [1:0] bresp);
      bit done = 0;
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk); #1;
         if (bus.awready === 1'b1 && bus.wready === 1'b1) done = 1;
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL write_accept addr=%h: no AWREADY/WREADY, required within 20 cycles", addr);
      end
      irq0 = irq;
      @(posedge clk); #1;
      irq1 = irq;
      bresp = bus.bresp;
      total++;
      if (bus.bvalid !== 1'b1) begin
         bad++;
         $display("FAIL write_bvalid addr=%h: bvalid=%b required 1", addr, bus.bvalid);
      end
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit done = 0;
      bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk); #1;
         if (bus.arready === 1'b1) done = 1;
      end
      bus.arvalid = 1'b0;
      data = bus.rdata;
      resp = bus.rresp;
      total++;
      if (!done || bus.rvalid !== 1'b1) begin
         bad++;
         $display("FAIL read_accept addr=%h: arready seen=%0d rvalid=%b required 1/1",
                  addr, done, bus.rvalid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [1:0]  r;
      logic [4:0]  addrs [5];
      addrs = '{5'h00, 5'h04, 5'h08, 5'h10, 5'h18};
      total++;
      if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0 ||
          bus.rdata !== 32'h0 || irq !== Inact) begin
         bad++;
         $display("FAIL reset_outputs: aw/w/b/ar/r=%b%b%b%b%b rdata=%h irq=%b required 00000 0 %b",
                  bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata, irq,
                  Inact);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      foreach (addrs[i]) begin
         axi_read(addrs[i], d, r);
         total++;
         if (d !== 32'h0 || r !== 2'b00) begin
            bad++;
            $display("FAIL reset_read addr=%h: data=%h resp=%b required 00000000 00",
                     addrs[i], d, r);
         end
      end
   endtask

   task automatic test_irq_flow();
      logic i0, i1;
      logic [1:0]  br, r;
      logic [31:0] d;
      axi_write(5'h00, 32'h1, 4'hf, i0, i1, br);
      axi_write(5'h04, 32'h1, 4'hf, i0, i1, br);
      intr_src = 1'b1;
      @(posedge clk); #1;
      intr_src = 1'b0;
      total++;
      if (irq !== Inact) begin
         bad++; $display("FAIL irq_at_event_edge: irq=%b required %b", irq, Inact);
      end
      @(posedge clk); #1;
      total++;
      if (irq !== Act) begin
         bad++; $display("FAIL irq_event_plus1: irq=%b required %b", irq, Act);
      end
      axi_read(5'h08, d, r);
      total++;
      if (d !== 32'h1) begin bad++; $display("FAIL isr_set: ISR=%h required 00000001", d); end
      axi_read(5'h10, d, r);
      total++;
      if (d !== 32'h1) begin bad++; $display("FAIL ipr_set: IPR=%h required 00000001", d); end
   endtask

   task automatic test_ack();
      logic i0, i1;
      logic [1:0]  br, r;
      logic [31:0] d;
      axi_write(5'h0C, 32'h1, 4'hf, i0, i1, br);
      total++;
      if (i0 !== Act || i1 !== Inact) begin
         bad++;
         $display("FAIL ack_irq_timing: irq at accept/accept+1=%b/%b required %b/%b",
                  i0, i1, Act, Inact);
      end
      axi_read(5'h10, d, r);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL ack_ipr: IPR=%h required 00000000", d); end
   endtask

   task automatic test_ier_gate();
      logic i0, i1;
      logic [1:0]  br, r;
      logic [31:0] d;
      axi_write(5'h04, 32'h0, 4'hf, i0, i1, br);
      intr_src = 1'b1;
      @(posedge clk); #1;
      intr_src = 1'b0;
      @(posedge clk); #1;
      total++;
      if (irq !== Inact) begin
         bad++; $display("FAIL gated_irq: irq=%b required %b", irq, Inact);
      end
      axi_read(5'h08, d, r);
      total++;
      if (d !== 32'h1) begin bad++; $display("FAIL gated_isr: ISR=%h required 00000001", d); end
      axi_read(5'h10, d, r);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL gated_ipr: IPR=%h required 00000000", d); end
      axi_read(5'h0C, d, r);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL iar_read: IAR=%h required 00000000", d); end
      axi_write(5'h04, 32'h1, 4'hf, i0, i1, br);
      total++;
      if (i1 !== Act) begin
         bad++; $display("FAIL ier_enable_irq: irq=%b required %b", i1, Act);
      end
      axi_write(5'h0C, 32'h1, 4'hf, i0, i1, br);
   endtask

   task automatic test_same_edge();
      logic i0, i1;
      logic [1:0]  br, r;
      logic [31:0] d;
      bus.awaddr = 5'h0C; bus.wdata = 32'h1; bus.wstrb = 4'hf;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
      intr_src = 1'b1;
      @(posedge clk); #1;
      intr_src = 1'b0;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      total++;
      if (bus.awready !== 1'b1) begin
         bad++; $display("FAIL same_edge_accept: awready=%b required 1", bus.awready);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      axi_read(5'h08, d, r);
      total++;
      if (d !== 32'h1) begin bad++; $display("FAIL set_wins: ISR=%h required 00000001", d); end
      axi_write(5'h0C, 32'h1, 4'hf, i0, i1, br);
      axi_read(5'h08, d, r);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL ack_clear: ISR=%h required 00000000", d); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  r;
      logic [31:0] d;
      bus.awaddr = 5'h04; bus.wdata = 32'h0; bus.wstrb = 4'hf;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
      @(posedge clk); #1;
      total++;
      if (bus.awready !== 1'b1) begin
         bad++; $display("FAIL bp_first_accept: awready=%b required 1", bus.awready);
      end
      bus.wdata = 32'h1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle %0d: bvalid/awready=%b/%b required 1/0",
                     i, bus.bvalid, bus.awready);
         end
      end
      bus.bready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus.bvalid !== 1'b0 || bus.awready !== 1'b0) begin
         bad++;
         $display("FAIL bp_handshake: bvalid/awready=%b/%b required 0/0", bus.bvalid, bus.awready);
      end
      @(posedge clk); #1;
      total++;
      if (bus.awready !== 1'b1) begin
         bad++; $display("FAIL bp_second_accept: awready=%b required 1", bus.awready);
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      axi_read(5'h04, d, r);
      total++;
      if (d !== 32'h1) begin bad++; $display("FAIL bp_ier: IER=%h required 00000001", d); end
   endtask

   task automatic test_strobe();
      logic i0, i1;
      logic [1:0]  br, r;
      logic [31:0] d;
      axi_write(5'h04, 32'h0, 4'hf, i0, i1, br);
      axi_write(5'h04, 32'hFFFF_FFFF, 4'b1110, i0, i1, br);
      axi_read(5'h04, d, r);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL strb_upper: IER=%h required 00000000", d); end
      axi_write(5'h04, 32'hFFFF_FFFF, 4'b0001, i0, i1, br);
      axi_read(5'h04, d, r);
      total++;
      if (d !== 32'h1) begin bad++; $display("FAIL strb_low: IER=%h required 00000001", d); end
      axi_write(5'h18, 32'hFFFF_FFFF, 4'hf, i0, i1, br);
      total++;
      if (br !== 2'b00) begin bad++; $display("FAIL unmapped_bresp: bresp=%b required 00", br); end
      axi_read(5'h18, d, r);
      total++;
      if (d !== 32'h0 || r !== 2'b00) begin
         bad++; $display("FAIL unmapped_read: data=%h resp=%b required 00000000 00", d, r);
      end
   endtask

   task automatic test_reset_mid();
      logic i0, i1;
      logic [1:0]  br, r;
      logic [31:0] d;
      axi_write(5'h00, 32'h1, 4'hf, i0, i1, br);
      intr_src = 1'b1;
      @(posedge clk); #1;
      intr_src = 1'b0;
      bus.awaddr = 5'h1C; bus.wdata = 32'h0; bus.wstrb = 4'hf;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (bus.bvalid !== 1'b1 || irq !== Act) begin
         bad++;
         $display("FAIL pre_reset: bvalid/irq=%b/%b required 1/%b", bus.bvalid, irq, Act);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.bvalid !== 1'b0 || bus.awready !== 1'b0 || irq !== Inact) begin
         bad++;
         $display("FAIL async_reset: bvalid/awready/irq=%b/%b/%b required 0/0/%b",
                  bus.bvalid, bus.awready, irq, Inact);
      end
      bus.bready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      axi_read(5'h00, d, r);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_gie: GIE=%h required 00000000", d); end
      axi_read(5'h04, d, r);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_ier: IER=%h required 00000000", d); end
      axi_read(5'h08, d, r);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_isr: ISR=%h required 00000000", d); end
   endtask

   initial begin
      idle_bus();
      intr_src = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_irq_flow();
      test_ack();
      test_ier_gate();
      test_same_edge();
      test_back_to_back();
      test_strobe();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
